// File: rtl/ex_bitcount_pkg.sv
// ex_bitcount_pkg: shared FSM state, sizing and count types for the sequential CLZ/CLO engine.
package ex_bitcount_pkg;
    typedef enum logic [1:0] {BC_IDLE, BC_SCAN, BC_DONE} bc_state_t;
    localparam int BC_DATA_W = 32;
    localparam int BYTES = BC_DATA_W / 8;
    typedef logic [3:0] bc_cnt_t;
endpackage

// File: rtl/ex_lead_byte_count.sv
// ex_lead_byte_count: leading count (0..8) of bits equal to bit_val in one byte.
module ex_lead_byte_count
    import ex_bitcount_pkg::*;
(
    input  logic       bit_val,
    input  logic [7:0] val,
    output bc_cnt_t    count
);
    // The most significant mismatching bit is visited last and so sets the count.
    always_comb begin
        count = 4'd8;
        for (int i = 0; i < 8; i++)
            if (val[i] != bit_val) count = 4'(7 - i);
    end
endmodule

// File: rtl/ex_bitcount_seq.sv
// ex_bitcount_seq: multi-cycle CLZ/CLO, one byte (two with EX_BITCOUNT_SEQ_DUAL_EN) per cycle, MSB first.
module ex_bitcount_seq
    import ex_bitcount_pkg::*;
#(
    parameter int DATA_W = BYTES * 8,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_clo,
    input  logic [DATA_W-1:0] operand,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);
    localparam int NB = DATA_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    bc_state_t         state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  acc_q, acc_d, res_q, res_d, sum;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic              clo_q, clo_d;
    logic [4:0]        cnt;
    logic              stop;
    bc_cnt_t           c_hi;

    ex_lead_byte_count u_hi (.bit_val(clo_q), .val(opnd_q[{idx_q, 3'b000} +: 8]), .count(c_hi));

`ifdef EX_BITCOUNT_SEQ_DUAL_EN
    localparam logic [IW-1:0] STEP = IW'(2);
    logic [IW-1:0] idx_lo;
    bc_cnt_t       c_lo;
    assign idx_lo = idx_q - IW'(1);
    ex_lead_byte_count u_lo (.bit_val(clo_q), .val(opnd_q[{idx_lo, 3'b000} +: 8]), .count(c_lo));
    assign cnt  = (c_hi != 4'd8) ? {1'b0, c_hi} : 5'd8 + {1'b0, c_lo};
    assign stop = (cnt != 5'd16) || (idx_q == IW'(1));
`else
    localparam logic [IW-1:0] STEP = IW'(1);
    assign cnt  = {1'b0, c_hi};
    assign stop = (cnt != 5'd8) || (idx_q == '0);
`endif

    assign sum = acc_q + CNT_W'(cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BC_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            opnd_q  <= '0;
            clo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            opnd_q  <= opnd_d;
            clo_q   <= clo_d;
        end
    end

    // IDLE and DONE accept identically, which gives back-to-back issue from DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        opnd_d  = opnd_q;
        clo_d   = clo_q;
        if (flush) begin
            state_d = BC_IDLE;
        end else if (state_q == BC_SCAN) begin
            state_d = stop ? BC_DONE : BC_SCAN;
            res_d   = stop ? sum : res_q;
            acc_d   = stop ? acc_q : sum;
            idx_d   = stop ? idx_q : idx_q - STEP;
        end else if (start) begin
            state_d = BC_SCAN;
            opnd_d  = operand;
            clo_d   = op_clo;
            idx_d   = IW'(NB - 1);
            acc_d   = '0;
        end else begin
            state_d = BC_IDLE;
        end
    end

    always_comb begin
        busy   = state_q == BC_SCAN;
        done   = state_q == BC_DONE;
        result = {{(32 - CNT_W){1'b0}}, res_q};
    end
endmodule

// File: tb/tb_ex_bitcount_seq.sv
// tb_ex_bitcount_seq: directed and random checks of ex_bitcount_seq against a latency/count model.
module tb_ex_bitcount_seq;
`ifdef EX_BITCOUNT_SEQ_DUAL_EN
    localparam int STEP_BITS = 16;
`else
    localparam int STEP_BITS = 8;
`endif
    localparam bit DUAL = (STEP_BITS == 16);

    logic        clk = 0, rst = 1, start = 0, op_clo = 0, flush = 0;
    logic [31:0] operand = 0;
    logic        busy, done;
    logic [31:0] result;
    int          tests = 0, fails = 0;

    ex_bitcount_seq dut (
        .clk(clk), .rst(rst), .start(start), .op_clo(op_clo), .operand(operand),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic int lc(input bit b, input logic [31:0] v);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i] != b) break;
            n++;
        end
        return n;
    endfunction

    // SCAN cycles = position of the first non-saturating chunk from the MSB side.
    function automatic int kof(input int r);
        return (r >= 32) ? 32 / STEP_BITS : r / STEP_BITS + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int m_left = 0, m_res = 0, m_pend = 0;
    bit m_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 0;
            m_res  <= 0;
            m_pend <= 0;
        end else if (flush) begin
            m_left <= 0;
            m_done <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_res <= m_pend;
        end else begin
            m_done <= 0;
            if (start) begin
                m_pend <= lc(op_clo, operand);
                m_left <= kof(lc(op_clo, operand));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("model done", {31'b0, done}, {31'b0, m_done});
            chk("model result", result, m_res);
        end
    end

    task automatic issue(input bit clo, input logic [31:0] v);
        start = 1;
        op_clo = clo;
        operand = v;
    endtask

    task automatic wait_done(input string name, input int exp_res, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clk);
            start = 0;
            operand = $urandom;
            n++;
        end while (!done && n < 20);
        chk({name, " latency"}, n, exp_lat);
        chk({name, " result"}, result, exp_res);
    endtask

    initial begin
        chk("pin lc zeros", lc(0, 32'h0), 32);
        chk("pin lc clo", lc(1, 32'hFFF0_1234), 12);
        chk("pin k max", kof(32), DUAL ? 2 : 4);
        #12;
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset done", {31'b0, done}, 0);
        chk("reset result", result, 0);
        #10 rst = 0;
        @(negedge clk);
        issue(0, 32'h00FF_FFFF); wait_done("clz 00ffffff", 8, DUAL ? 2 : 3);
        @(negedge clk);
        issue(0, 32'h0);         wait_done("clz zero", 32, DUAL ? 3 : 5);
        @(negedge clk);
        issue(1, 32'hFFFF_FFFF); wait_done("clo ones", 32, DUAL ? 3 : 5);
        @(negedge clk);
        issue(1, 32'hFFF0_1234); wait_done("clo fff01234", 12, DUAL ? 2 : 3);
        @(negedge clk);
        issue(0, 32'h8000_0000); wait_done("clz 80000000", 0, 2);
        @(negedge clk);
        issue(0, 32'h0000_0100); wait_done("b2b first", 23, DUAL ? 3 : 4);
        issue(1, 32'hE000_0000); wait_done("b2b second", 3, 2);
        // Flush lands in the second SCAN cycle; no done may follow.
        @(negedge clk);
        issue(0, 32'h1);
        @(negedge clk); start = 0;
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        chk("flush busy", {31'b0, busy}, 0);
        for (int i = 0; i < 5; i++) begin
            chk("flush no done", {31'b0, done}, 0);
            @(negedge clk);
        end
        chk("flush result held", result, 3);
        issue(0, 32'h0); flush = 1;
        @(negedge clk); start = 0; flush = 0;
        chk("flush+start busy", {31'b0, busy}, 0);
        @(negedge clk);
        chk("flush+start done", {31'b0, done}, 0);
        chk("flush+start result", result, 3);
        issue(0, 32'h0);
        @(negedge clk); start = 0;
        chk("pre-reset busy", {31'b0, busy}, 1);
        #2 rst = 1;
        #1;
        chk("async rst busy", {31'b0, busy}, 0);
        chk("async rst done", {31'b0, done}, 0);
        chk("async rst result", result, 0);
        @(negedge clk);
        #2 rst = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            flush = ($urandom % 20) == 0;
            op_clo = $urandom % 2;
            operand = $urandom >> ($urandom % 33);
            if (op_clo) operand = ~operand;
        end
        @(negedge clk);
        start = 0;
        flush = 0;
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_bitcount_seq.md
Name: ex_bitcount_seq

Overview:
- Multi-cycle CLZ/CLO engine for the EX stage. It scans a 32-bit operand one byte per cycle, MSB byte first, using a single byte-wide leading-count unit, and stops early at the first byte that does not saturate.
- It trades the four parallel byte units plus the combinational merge for one shared unit and a small FSM.
- The EX stage stalls on busy and consumes result on the done pulse.

Parameters:
- DATA_W, 32, operand width; must be a multiple of 8 (8..32).
- CNT_W, $clog2(DATA_W)+1, width of the internal accumulator (6 for 32).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; operand and op_clo sampled when start=1 and the block is in IDLE or DONE
- op_clo  in  1  1 = count leading ones (CLO), 0 = count leading zeros (CLZ)
- operand  in  DATA_W  value to scan
- flush  in  1  pipeline flush; aborts any operation in progress
- busy  out  1  high in SCAN (EX must stall)
- done  out  1  one-cycle pulse; result valid this cycle
- result  out  32  leading count, zero-extended; held until the next accepted start

Behaviour:
- Reset is asynchronous: state=IDLE, busy=0, done=0, result=0, byte index=0, accumulator=0, latched operand=0, latched op_clo=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 and flush=0: latch operand and op_clo, set idx=DATA_W/8-1, acc=0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (busy=1):
  - Byte unit computes c (0..8) = leading count of byte[idx] for the latched op_clo.
  - Stop when c!=8 or idx==0: result <= acc+c, go to DONE.
  - Otherwise: acc <= acc+8, idx <= idx-1, stay in SCAN.
  - start is ignored in SCAN.
- DONE (done=1, busy=0, lasts exactly one cycle):
  - start=1 and flush=0: accept the new operand, go to SCAN (back-to-back issue).
  - Otherwise go to IDLE.
- Latency, measured from the start-sampled edge:
  - SCAN occupies k cycles, k = index of the first non-saturating byte from the MSB (1..4).
  - done is high in cycle T+k+1.
  - Minimum is 2 cycles (byte3 terminates); maximum is 5 cycles (operand all zeros for CLZ, or all ones for CLO).
- Arithmetic:
  - acc+c never exceeds DATA_W.
  - result = {zeros, acc+c}; the all-zeros CLZ result is 32 (0x20).
- flush:
  - In any state, forces IDLE next cycle; no done pulse for the aborted operation; result keeps its previous value.
  - flush together with start: flush wins and start is dropped.
- Reset mid-SCAN: immediate return to IDLE and all outputs cleared.
- Operand changes during SCAN have no effect; only the latched copy is used.

Optional Feature:
- Macro: EX_BITCOUNT_SEQ_DUAL_EN.
- Defined:
  - Two byte units scan bytes idx and idx-1 per SCAN cycle; idx steps by 2.
  - Per-cycle count c2 = c_hi if c_hi!=8, else 8+c_lo.
  - Stop when c2!=16 or idx==1.
  - k is 1..2, so maximum latency is 3 cycles.
  - DATA_W must be a multiple of 16.
- Undefined: single byte unit, behaviour exactly as above.
- done/result semantics and flush rules are identical in both builds.

Decomposition:
- Shared package (ex_bitcount_pkg):
  - typedef enum logic [1:0] for bc_state_t {BC_IDLE, BC_SCAN, BC_DONE};
  - localparam BYTES = DATA_W/8;
  - byte count type logic [3:0].
- One natural sub-module: ex_lead_byte_count.
  - Ports: bit_val, val[7:0] in; count[3:0] out.
  - Purely combinational; instantiated once, or twice with EX_BITCOUNT_SEQ_DUAL_EN.

Test Plan:
- CLZ 0x00FFFFFF, start at T: busy high T+1..T+2, done at T+3, result=8.
- CLZ 0x00000000: 4 SCAN cycles, done at T+5, result=32. CLO 0xFFFFFFFF: same timing, result=32.
- CLO 0xFFF0_1234: terminates at byte2, done at T+3, result=12. CLZ 0x80000000: done at T+2, result=0.
- Back-to-back issue:
  - Step 1: CLZ 0x0000_0100 (result=23, done at T+4).
  - Step 2: start CLO 0xE0000000 in the done cycle.
  - Required: no IDLE bubble, second done 2 cycles later with result=3.
- flush in the second SCAN cycle of CLZ 0x00000001: no done pulse, return to IDLE, result keeps its prior value.
- flush together with start in IDLE: start is ignored.
- Reset asserted asynchronously mid-SCAN: outputs 0 immediately.
- With EX_BITCOUNT_SEQ_DUAL_EN: CLZ 0x00000000 gives done at T+3, result=32.
